// File: rtl/wr_buf_ctrl.sv
// In-order write buffer feeding a single service FSM that resolves each head
// entry against the tag list (write-back/allocate or write-through/no-allocate).
module wr_buf_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LINE_WORDS = 32,
  parameter int BUF_DEPTH  = 4,
  localparam int TAG_W  = $clog2(LIST_DEPTH),
  localparam int OFF_W  = $clog2(LINE_WORDS),
  localparam int STRB_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(BUF_DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [STRB_W-1:0]      wr_strb,
  input  logic                   wr_wt,
  output logic [CNT_W-1:0]       buf_count,
  output logic                   lk_req,
  output logic [ADDR_W-1:0]      lk_addr,
  input  logic                   lk_rsp_valid,
  input  logic                   lk_hit,
  input  logic [TAG_W-1:0]       lk_tag,
  output logic                   alloc_req,
  input  logic                   alloc_gnt,
  input  logic [TAG_W-1:0]       alloc_tag,
  input  logic                   rd_busy,
  input  logic [ADDR_W-1:0]      rd_busy_addr,
  output logic                   fetch_req,
  input  logic                   fetch_gnt,
  output logic [ADDR_W-1:0]      fetch_addr,
  output logic [TAG_W-1:0]       fetch_tag,
  input  logic                   fetch_done,
  output logic                   mem_wen,
  input  logic                   mem_wready,
  output logic [TAG_W+OFF_W-1:0] mem_waddr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [STRB_W-1:0]      mem_wstrb,
  output logic                   dirty_set,
  output logic [TAG_W-1:0]       dirty_tag,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  output logic [ADDR_W-1:0]      dn_addr,
  output logic [DATA_W-1:0]      dn_data,
  output logic [STRB_W-1:0]      dn_strb,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_ALLOC     = 3'd3,
    S_FETCH     = 3'd4,
    S_WAIT_FILL = 3'd5,
    S_WRITE     = 3'd6,
    S_DOWN      = 3'd7
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_mem [BUF_DEPTH];
  logic [DATA_W-1:0] data_mem [BUF_DEPTH];
  logic [STRB_W-1:0] strb_mem [BUF_DEPTH];
  logic              wt_mem   [BUF_DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             lk_issued;
  logic [TAG_W-1:0] slot;

  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic [STRB_W-1:0] h_strb;
  logic              h_wt;
  logic [ADDR_W-1:0] line_addr;

  // Every valid/request output is held, with a stable payload, until the
  // same-cycle partner ready/grant is seen; a partner already high counts.
  assign wr_ready  = (count != CNT_W'(BUF_DEPTH));
  assign push      = wr_valid && wr_ready;
  assign buf_count = count;
  assign dbg_state = state;

  assign h_addr    = addr_mem[rptr];
  assign h_data    = data_mem[rptr];
  assign h_strb    = strb_mem[rptr];
  assign h_wt      = wt_mem[rptr];
  assign line_addr = {h_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= wr_addr;
      data_mem[wptr] <= wr_data;
      strb_mem[wptr] <= wr_strb;
      wt_mem[wptr]   <= wr_wt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lk_issued <= 1'b0;
      slot      <= '0;
    end else begin
      state     <= next_state;
      // lk_req fires only on the first LOOKUP cycle, including re-entry from WAIT_RD.
      lk_issued <= (state == S_LOOKUP) && (next_state == S_LOOKUP);
      if (state == S_LOOKUP && lk_rsp_valid && lk_hit) slot <= lk_tag;
      else if (state == S_ALLOC && alloc_gnt)          slot <= alloc_tag;
    end
  end

  always_comb begin
    next_state = state;
    lk_req     = 1'b0;
    alloc_req  = 1'b0;
    fetch_req  = 1'b0;
    mem_wen    = 1'b0;
    dirty_set  = 1'b0;
    dn_valid   = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        lk_req = !lk_issued;
        if (lk_rsp_valid) begin
          if (lk_hit)                                      next_state = S_WRITE;
          else if (h_wt)                                   next_state = S_DOWN;
          else if (rd_busy && (rd_busy_addr == line_addr)) next_state = S_WAIT_RD;
          else                                             next_state = S_ALLOC;
        end
      end
      S_WAIT_RD: begin
        if (!rd_busy) next_state = S_LOOKUP;
      end
      S_ALLOC: begin
        alloc_req = 1'b1;
        if (alloc_gnt) next_state = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_gnt) next_state = S_WAIT_FILL;
      end
      S_WAIT_FILL: begin
        if (fetch_done) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_wen = 1'b1;
        if (mem_wready) begin
          if (h_wt) begin
            next_state = S_DOWN;
          end else begin
            dirty_set  = 1'b1;
            pop        = 1'b1;
            next_state = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        dn_valid = 1'b1;
        if (dn_ready) begin
          pop        = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Payloads read zero whenever their qualifier is low.
  assign lk_addr    = lk_req    ? line_addr : '0;
  assign fetch_addr = fetch_req ? line_addr : '0;
  assign fetch_tag  = fetch_req ? slot      : '0;
  assign mem_waddr  = mem_wen   ? {slot, h_addr[OFF_W-1:0]} : '0;
  assign mem_wdata  = mem_wen   ? h_data    : '0;
  assign mem_wstrb  = mem_wen   ? h_strb    : '0;
  assign dirty_tag  = dirty_set ? slot      : '0;
  assign dn_addr    = dn_valid  ? h_addr    : '0;
  assign dn_data    = dn_valid  ? h_data    : '0;
  assign dn_strb    = dn_valid  ? h_strb    : '0;

endmodule

// File: tb/tb_wr_buf_ctrl.sv
// Directed bench for wr_buf_ctrl: rule-based scoreboard of buffered writes plus
// hand-computed literal expectations for each scenario.
module tb_wr_buf_ctrl;

  logic        clk, rst;
  logic        wr_valid, wr_ready, wr_wt;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [2:0]  buf_count;
  logic        lk_req, lk_rsp_valid, lk_hit;
  logic [31:0] lk_addr;
  logic [1:0]  lk_tag;
  logic        alloc_req, alloc_gnt;
  logic [1:0]  alloc_tag;
  logic        rd_busy;
  logic [31:0] rd_busy_addr;
  logic        fetch_req, fetch_gnt, fetch_done;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_tag;
  logic        mem_wen, mem_wready;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        dirty_set;
  logic [1:0]  dirty_tag;
  logic        dn_valid, dn_ready;
  logic [31:0] dn_addr, dn_data;
  logic [3:0]  dn_strb;
  logic [2:0]  dbg_state;

  wr_buf_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_wt(wr_wt), .buf_count(buf_count),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit),
    .lk_tag(lk_tag), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .rd_busy(rd_busy), .rd_busy_addr(rd_busy_addr),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_addr(fetch_addr),
    .fetch_tag(fetch_tag), .fetch_done(fetch_done),
    .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dirty_set(dirty_set), .dirty_tag(dirty_tag),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_strb(dn_strb), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        wt;
  } ent_t;

  logic [68:0] exp_q[$];
  logic [31:0] done_q[$];
  logic [1:0]  cache_tag [logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;

  logic       m_hit, m_alloc, m_mem;
  logic [1:0] m_slot;
  logic       p_lk, p_alloc, p_fetch, p_mem, p_dn;
  logic [127:0] pv_fetch, pv_mem, pv_dn;

  int n_lk = 0, n_alloc_req = 0, n_fetch_cyc = 0, n_fetch_hs = 0;
  int n_mem_hs = 0, n_dirty = 0, n_dn_hs = 0;
  logic [31:0] last_lk, last_fetch_addr, last_wdata, last_dn_addr;
  logic [1:0]  last_fetch_tag, last_dirty_tag;
  logic [6:0]  last_waddr;
  logic [3:0]  last_dn_strb;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:5], 5'd0};
  endfunction

  function void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- lookup responder (one cycle after lk_req) ----------------
  logic        lk_pend;
  logic [31:0] lk_pend_addr;
  always begin
    @(negedge clk);
    lk_pend      = lk_req && !rst;
    lk_pend_addr = lk_addr;
    @(posedge clk); #1;
    lk_rsp_valid = lk_pend;
    lk_hit       = lk_pend && cache_tag.exists(lk_pend_addr);
    lk_tag       = (lk_pend && cache_tag.exists(lk_pend_addr)) ? cache_tag[lk_pend_addr] : 2'd0;
  end

  // ---------------- compare process ----------------
  always begin
    ent_t hd;
    logic busy;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      {m_hit, m_alloc, m_mem, m_slot} = '0;
      {p_lk, p_alloc, p_fetch, p_mem, p_dn} = '0;
    end else begin
      check("buf_count", buf_count, exp_q.size());
      check("wr_ready", wr_ready, exp_q.size() < 4);
      if (p_alloc) check("alloc_hold", alloc_req, 1);
      if (p_fetch) check("fetch_hold", {fetch_req, fetch_addr, fetch_tag}, pv_fetch);
      if (p_mem)   check("mem_hold", {mem_wen, mem_waddr, mem_wdata, mem_wstrb}, pv_mem);
      if (p_dn)    check("dn_hold", {dn_valid, dn_addr, dn_data, dn_strb}, pv_dn);

      if (lk_req) begin n_lk++; last_lk = lk_addr; end
      if (alloc_req) n_alloc_req++;
      if (fetch_req) n_fetch_cyc++;
      if (fetch_req && fetch_gnt) begin
        n_fetch_hs++; last_fetch_addr = fetch_addr; last_fetch_tag = fetch_tag;
      end
      if (mem_wen && mem_wready) begin
        n_mem_hs++; last_waddr = mem_waddr; last_wdata = mem_wdata;
      end
      if (dirty_set) begin n_dirty++; last_dirty_tag = dirty_tag; end
      if (dn_valid && dn_ready) begin
        n_dn_hs++; last_dn_addr = dn_addr; last_dn_strb = dn_strb;
      end

      busy = lk_req | alloc_req | fetch_req | mem_wen | dn_valid | dirty_set;
      if (exp_q.size() == 0) begin
        if (busy) check("idle_quiet", busy, 0);
      end else begin
        hd = ent_t'(exp_q[0]);
        if (lk_req) begin
          check("lk_pulse", p_lk, 0);
          check("lk_addr", lk_addr, line_of(hd.addr));
        end
        if (lk_rsp_valid) begin
          m_hit = lk_hit;
          if (lk_hit) m_slot = lk_tag;
        end
        if (alloc_req) check("alloc_rule", {hd.wt, m_hit}, 0);
        if (alloc_req && alloc_gnt) begin m_slot = alloc_tag; m_alloc = 1'b1; end
        if (fetch_req) begin
          check("fetch_rule", m_alloc, 1);
          check("fetch_payload", {fetch_addr, fetch_tag}, {line_of(hd.addr), m_slot});
        end
        if (mem_wen) begin
          check("mem_rule", m_hit | m_alloc, 1);
          check("mem_payload", {mem_waddr, mem_wdata, mem_wstrb},
                {m_slot, hd.addr[4:0], hd.data, hd.strb});
        end
        check("dirty_set", dirty_set, mem_wen && mem_wready && !hd.wt);
        if (dirty_set) check("dirty_tag", dirty_tag, m_slot);
        if (dn_valid) begin
          check("dn_rule", hd.wt && (!m_hit || m_mem), 1);
          check("dn_payload", {dn_addr, dn_data, dn_strb}, {hd.addr, hd.data, hd.strb});
        end
        if (mem_wen && mem_wready) m_mem = 1'b1;
        if ((mem_wen && mem_wready && !hd.wt) || (dn_valid && dn_ready)) begin
          done_q.push_back(hd.addr);
          void'(exp_q.pop_front());
          {m_hit, m_alloc, m_mem, m_slot} = '0;
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back({wr_addr, wr_data, wr_strb, wr_wt});

      p_lk     = lk_req;
      p_alloc  = alloc_req && !alloc_gnt;
      p_fetch  = fetch_req && !fetch_gnt;
      p_mem    = mem_wen && !mem_wready;
      p_dn     = dn_valid && !dn_ready;
      pv_fetch = {fetch_req, fetch_addr, fetch_tag};
      pv_mem   = {mem_wen, mem_waddr, mem_wdata, mem_wstrb};
      pv_dn    = {dn_valid, dn_addr, dn_data, dn_strb};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic wt);
    int n;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s; wr_wt = wt;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 200) begin @(negedge clk); n++; end
    check("push_accept", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((buf_count != 0 || dbg_state != 3'd0) && n < 300) begin @(negedge clk); n++; end
    check("drain", {buf_count, dbg_state}, 0);
    @(posedge clk); #1;
  endtask

  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  int b_lk, b_alloc, b_fetch_cyc, b_fetch_hs, b_mem, b_dirty, b_dn, b_done, n;

  initial begin
    rst = 1'b1;
    {wr_valid, wr_wt, wr_addr, wr_data, wr_strb} = '0;
    {lk_rsp_valid, lk_hit, lk_tag} = '0;
    {alloc_gnt, alloc_tag, rd_busy, rd_busy_addr} = '0;
    {fetch_gnt, fetch_done, mem_wready, dn_ready} = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_outputs", |{lk_req, lk_addr, alloc_req, fetch_req, fetch_addr, fetch_tag,
                           mem_wen, mem_waddr, mem_wdata, mem_wstrb, dirty_set, dirty_tag,
                           dn_valid, dn_addr, dn_data, dn_strb}, 0);
    check("rst_count", buf_count, 0);
    check("rst_ready", wr_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // 1: write-back hit, tag 2
    cache_tag[32'h40] = 2'd2;
    mem_wready = 1'b1;
    b_lk = n_lk; b_dirty = n_dirty;
    push(32'h45, 32'hDEADBEEF, 4'hF, 1'b0);
    wait_idle();
    check("t1_lk_count", n_lk - b_lk, 1);
    check("t1_lk_addr", last_lk, 32'h40);
    check("t1_waddr", last_waddr, 7'h45);
    check("t1_wdata", last_wdata, 32'hDEADBEEF);
    check("t1_dirty_count", n_dirty - b_dirty, 1);
    check("t1_dirty_tag", last_dirty_tag, 2'd2);
    check("t1_count", buf_count, 0);

    // 2: write-back miss, allocate slot 1, fetch grant withheld 3 cycles
    alloc_gnt = 1'b1; alloc_tag = 2'd1; fetch_gnt = 1'b0;
    b_alloc = n_alloc_req; b_fetch_cyc = n_fetch_cyc;
    push(32'h80, 32'h11112222, 4'hF, 1'b0);
    n = 0;
    @(negedge clk);
    while (!fetch_req && n < 50) begin @(negedge clk); n++; end
    check("t2_fetch_seen", fetch_req, 1);
    repeat (2) begin @(negedge clk); check("t2_fetch_held", fetch_req, 1); end
    @(posedge clk); #1; fetch_gnt = 1'b1;
    step(1); fetch_gnt = 1'b0; alloc_gnt = 1'b0;
    step(2); fetch_done = 1'b1;
    step(1); fetch_done = 1'b0;
    wait_idle();
    check("t2_alloc_cycles", n_alloc_req - b_alloc, 1);
    check("t2_fetch_cycles", n_fetch_cyc - b_fetch_cyc, 4);
    check("t2_fetch_addr", last_fetch_addr, 32'h80);
    check("t2_fetch_tag", last_fetch_tag, 2'd1);
    check("t2_waddr", last_waddr, 7'h20);
    check("t2_dirty_tag", last_dirty_tag, 2'd1);

    // 3: write-through miss goes straight downstream
    dn_ready = 1'b0;
    b_alloc = n_alloc_req; b_mem = n_mem_hs; b_dn = n_dn_hs;
    push(32'h123, 32'hCAFE0123, 4'h3, 1'b1);
    n = 0;
    @(negedge clk);
    while (!dn_valid && n < 50) begin @(negedge clk); n++; end
    check("t3_dn_seen", dn_valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; dn_ready = 1'b1;
    wait_idle();
    dn_ready = 1'b0;
    check("t3_no_alloc", n_alloc_req - b_alloc, 0);
    check("t3_no_mem", n_mem_hs - b_mem, 0);
    check("t3_dn_count", n_dn_hs - b_dn, 1);
    check("t3_dn_addr", last_dn_addr, 32'h123);
    check("t3_dn_strb", last_dn_strb, 4'h3);

    // 4: miss on a line the reader is filling waits, then re-looks up and hits
    rd_busy = 1'b1; rd_busy_addr = 32'h80;
    b_lk = n_lk; b_alloc = n_alloc_req;
    push(32'h84, 32'h44445555, 4'hC, 1'b0);
    repeat (8) @(negedge clk);
    check("t4_one_lookup", n_lk - b_lk, 1);
    check("t4_no_alloc_wait", n_alloc_req - b_alloc, 0);
    check("t4_pending", buf_count, 1);
    @(posedge clk); #1;
    cache_tag[32'h80] = 2'd3;
    rd_busy = 1'b0;
    wait_idle();
    check("t4_two_lookups", n_lk - b_lk, 2);
    check("t4_no_alloc", n_alloc_req - b_alloc, 0);
    check("t4_waddr", last_waddr, 7'h64);
    check("t4_dirty_tag", last_dirty_tag, 2'd3);

    // 5: fill the buffer with RAM stalled, fifth push waits, order preserved
    cache_tag[32'h200] = 2'd0;
    mem_wready = 1'b0;
    b_mem = n_mem_hs; b_done = done_q.size();
    for (int i = 0; i < 4; i++) push(32'h200 + i, 32'h50000000 + i, 4'hF, 1'b0);
    @(negedge clk);
    check("t5_full_ready", wr_ready, 0);
    check("t5_full_count", buf_count, 4);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 32'h204; wr_data = 32'h50000004; wr_strb = 4'hF; wr_wt = 1'b0;
    repeat (3) begin @(negedge clk); check("t5_stall_count", buf_count, 4); end
    @(posedge clk); #1; mem_wready = 1'b1;
    push(32'h204, 32'h50000004, 4'hF, 1'b0);
    wait_idle();
    check("t5_mem_count", n_mem_hs - b_mem, 5);
    check("t5_done_count", done_q.size() - b_done, 5);
    for (int i = 0; i < 5; i++)
      if (b_done + i < done_q.size()) check("t5_order", done_q[b_done + i], 32'h200 + i);

    // 6: reset while waiting for a fill; later fetch_done is ignored
    alloc_gnt = 1'b1; alloc_tag = 2'd2; fetch_gnt = 1'b1;
    b_fetch_hs = n_fetch_hs;
    push(32'h305, 32'h66667777, 4'hF, 1'b0);
    n = 0;
    @(negedge clk);
    while (n_fetch_hs == b_fetch_hs && n < 50) begin @(negedge clk); n++; end
    check("t6_fetch_hs", n_fetch_hs - b_fetch_hs, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; alloc_gnt = 1'b0; fetch_gnt = 1'b0;
    @(negedge clk);
    check("t6_rst_outputs", |{lk_req, lk_addr, alloc_req, fetch_req, fetch_addr, fetch_tag,
                              mem_wen, mem_waddr, mem_wdata, mem_wstrb, dirty_set, dirty_tag,
                              dn_valid, dn_addr, dn_data, dn_strb}, 0);
    check("t6_rst_count", buf_count, 0);
    check("t6_rst_ready", wr_ready, 1);
    @(posedge clk); #1; rst = 1'b0;
    b_lk = n_lk; b_mem = n_mem_hs; b_dirty = n_dirty;
    step(1); fetch_done = 1'b1;
    step(1); fetch_done = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_mem", n_mem_hs - b_mem, 0);
    check("t6_no_dirty", n_dirty - b_dirty, 0);
    check("t6_no_lookup", n_lk - b_lk, 0);
    check("t6_idle", {buf_count, dbg_state}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
